// File: rtl/jk_sched_pkg.sv
// Shared definitions for the JK bank scheduler: command opcodes, FSM state
// encoding and the round-robin winner search.
package jk_sched_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } st_e;

    // First set bit of valid[n-1:0], searching ptr, ptr+1, ... mod n; -1 if none.
    function automatic int rr_pick(input logic [31:0] valid, input int n, input int ptr);
        int idx;
        rr_pick = -1;
        for (int k = 0; k < n; k++) begin
            idx = (ptr + k) % n;
            if (rr_pick < 0 && ((valid >> idx) & 32'd1) != 32'd0) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop cell with synchronous active-high reset to 0.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler driving J/K of one addressed cell in a bank of JK flops.
// state | meaning:  ST_IDLE | arbitrating, ready to accept;  ST_EXEC | driving cell, cnt cycles left
module jk_bank_sched
    import jk_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int AW    = 3,
    parameter int LW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [AW*NREQ-1:0]       req_addr,
    input  logic [LW*NREQ-1:0]       req_len,
    output logic [NBITS-1:0]         q,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     err
);

    localparam int GW = $clog2(NREQ);

    st_e            state_q, state_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]  gnt_q, gnt_d;
    logic [1:0]     op_q, op_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           first_q, first_d;

    int             win;
    logic [GW-1:0]  win_idx;
    logic           accept;
    logic [1:0]     sel_op;
    logic [AW-1:0]  sel_addr;
    logic [LW-1:0]  sel_len;
    logic           addr_hit;
    logic [NBITS-1:0] j_vec, k_vec, qbar_unused;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        first_d   = 1'b0;
        req_ready = '0;
        sel_op    = OP_HOLD;
        sel_addr  = '0;
        sel_len   = '0;
        addr_hit  = 1'b0;
        j_vec     = '0;
        k_vec     = '0;

        win     = rr_pick(32'(req_valid), NREQ, int'(rr_ptr_q));
        win_idx = GW'(win);
        accept  = (state_q == ST_IDLE) && !rst && (win >= 0);

        for (int i = 0; i < NREQ; i++) begin
            if (win == i) begin
                sel_op       = req_op[2*i +: 2];
                sel_addr     = req_addr[AW*i +: AW];
                sel_len      = req_len[LW*i +: LW];
                req_ready[i] = accept;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_EXEC;
                    gnt_d    = win_idx;
                    rr_ptr_d = (win_idx == GW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    op_d     = sel_op;
                    addr_d   = sel_addr;
                    cnt_d    = (sel_op == OP_TOGGLE) ? sel_len : '0;
                    first_d  = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Out-of-range addresses match no cell, so they drive nothing and flag err.
        for (int b = 0; b < NBITS; b++) begin
            if (addr_q == AW'(b)) begin
                addr_hit = 1'b1;
                if (state_q == ST_EXEC) begin
                    j_vec[b] = op_q[1];
                    k_vec[b] = op_q[0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            op_q     <= OP_HOLD;
            addr_q   <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NBITS; g++) begin : g_cell
            jk_cell u_cell (
                .clk  (clk),
                .rst  (rst),
                .j    (j_vec[g]),
                .k    (k_vec[g]),
                .q    (q[g]),
                .qbar (qbar_unused[g])
            );
        end
    endgenerate

    assign busy   = (state_q == ST_EXEC);
    assign gnt_id = gnt_q;
    assign err    = first_q & ~addr_hit;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: directed scenarios plus random traffic against a command-level model.
module tb_jk_bank_sched;
    import jk_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [11:0] req_addr, req_len;
    logic [3:0]  ready8, ready6;
    logic [7:0]  q8;
    logic [5:0]  q6;
    logic        busy8, busy6, err8, err6;
    logic [1:0]  gnt8, gnt6;

    always #5 clk = ~clk;

    jk_bank_sched #(.NREQ(4), .NBITS(8), .AW(3), .LW(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready8), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len), .q(q8), .busy(busy8), .gnt_id(gnt8), .err(err8)
    );

    // Six-cell bank leaves addresses 6 and 7 out of range for the error path.
    jk_bank_sched #(.NREQ(4), .NBITS(6), .AW(3), .LW(3)) dut6 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready6), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len), .q(q6), .busy(busy6), .gnt_id(gnt6), .err(err6)
    );

    int vecs = 0;
    int errs = 0;

    // Reference: a command is pending for m_rem more cycles once accepted.
    bit [7:0] m_q;
    bit       m_busy, m_first;
    int       m_rem, m_ptr, m_gnt, m_op, m_addr;

    function automatic int m_winner();
        int idx;
        if (rst || m_busy) return -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (req_valid[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int w;
        w = m_winner();
        return (w < 0) ? 4'h0 : 4'(4'b1 << w);
    endfunction

    task automatic model_edge();
        int w, len;
        w = m_winner();
        if (rst) begin
            m_q = '0; m_busy = 0; m_first = 0; m_ptr = 0; m_gnt = 0; m_rem = 0;
        end else if (m_busy) begin
            case (m_op)
                1: m_q[m_addr[2:0]] = 1'b0;
                2: m_q[m_addr[2:0]] = 1'b1;
                3: m_q[m_addr[2:0]] = ~m_q[m_addr[2:0]];
                default: ;
            endcase
            m_first = 0;
            m_rem--;
            if (m_rem == 0) m_busy = 0;
        end else if (w >= 0) begin
            m_op   = int'((req_op >> (2 * w)) & 8'h3);
            m_addr = int'((req_addr >> (3 * w)) & 12'h7);
            len    = int'((req_len >> (3 * w)) & 12'h7);
            m_rem  = (m_op == 3) ? len + 1 : 1;
            m_busy = 1; m_first = 1; m_gnt = w; m_ptr = (w + 1) % 4;
        end
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input bit [1:0] op,
                           input bit [2:0] a, input bit [2:0] l);
        req_valid = v ? (req_valid | 4'(4'b1 << i)) : (req_valid & ~4'(4'b1 << i));
        req_op    = (req_op & ~8'(8'h3 << (2 * i))) | 8'(8'(op) << (2 * i));
        req_addr  = (req_addr & ~12'(12'h7 << (3 * i))) | 12'(12'(a) << (3 * i));
        req_len   = (req_len & ~12'(12'h7 << (3 * i))) | 12'(12'(l) << (3 * i));
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_op = '0; req_addr = '0; req_len = '0;
        repeat (2) begin
            #1; vecs++;
            if (ready8 !== 4'h0) begin errs++; $display("FAIL reset_ready got=%b exp=0000", ready8); end
            tick();
        end
        #1; vecs++;
        if ({q8, busy8, err8, gnt8} !== 12'h000) begin
            errs++; $display("FAIL reset_state q=%h busy=%b err=%b gnt=%0d exp all zero", q8, busy8, err8, gnt8);
        end
        rst = 1'b0; #1; vecs++;
        if (ready8 !== 4'b0001) begin errs++; $display("FAIL reset_first_grant got=%b exp=0001", ready8); end
        tick();
        req_valid = '0; #1; vecs++;
        if (busy8 !== 1'b1) begin errs++; $display("FAIL reset_hold_busy got=%b exp=1", busy8); end
        tick();
        #1; vecs++;
        if (busy8 !== 1'b0) begin errs++; $display("FAIL reset_hold_done got=%b exp=0", busy8); end
    endtask

    task automatic test_single_set();
        req_valid = '0;
        set_req(1, 1, OP_SET, 3'd5, 3'd0); #1; vecs++;
        if ({busy8, ready8} !== 5'b0_0010) begin errs++; $display("FAIL set_ready got=%b%b exp=00010", busy8, ready8); end
        tick();
        req_valid = '0; #1; vecs++;
        if ({busy8, ready8, gnt8, q8} !== {1'b1, 4'b0000, 2'd1, 8'h00}) begin
            errs++; $display("FAIL set_exec busy=%b ready=%b gnt=%0d q=%h exp 1/0000/1/00", busy8, ready8, gnt8, q8);
        end
        tick();
        #1; vecs++;
        if ({busy8, q8} !== {1'b0, 8'h20}) begin errs++; $display("FAIL set_result busy=%b q=%h exp 0/20", busy8, q8); end
    endtask

    task automatic test_fairness();
        int order[3];
        rst = 1'b1; req_valid = '0; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1, OP_SET, 3'(i), 3'd0);
        for (int n = 0; n < 4; n++) begin
            #1; vecs++;
            if (ready8 !== 4'(4'b1 << n)) begin errs++; $display("FAIL fair_order n=%0d got=%b", n, ready8); end
            tick();
            set_req(n, 0, OP_SET, 3'(n), 3'd0); #1; vecs++;
            if ({busy8, ready8, gnt8} !== {1'b1, 4'b0000, 2'(n)}) begin
                errs++; $display("FAIL fair_exec n=%0d busy=%b ready=%b gnt=%0d", n, busy8, ready8, gnt8);
            end
            tick();
        end
        #1; vecs++;
        if (q8 !== 8'h0F) begin errs++; $display("FAIL fair_q got=%h exp=0f", q8); end
        order = '{0, 2, 3};
        set_req(0, 1, OP_SET, 3'd4, 3'd0);
        set_req(2, 1, OP_SET, 3'd6, 3'd0);
        set_req(3, 1, OP_SET, 3'd7, 3'd0);
        for (int n = 0; n < 3; n++) begin
            #1; vecs++;
            if (ready8 !== 4'(4'b1 << order[n])) begin
                errs++; $display("FAIL fair_reorder n=%0d got=%b exp_id=%0d", n, ready8, order[n]);
            end
            tick();
            set_req(order[n], 0, OP_SET, 3'd0, 3'd0);
            tick();
        end
        #1; vecs++;
        if (q8 !== 8'hDF) begin errs++; $display("FAIL fair_q2 got=%h exp=df", q8); end
    endtask

    task automatic test_toggle();
        req_valid = '0;
        set_req(1, 1, OP_RESET, 3'd2, 3'd0); tick();
        req_valid = '0; tick();
        set_req(1, 1, OP_TOGGLE, 3'd2, 3'd4); #1; vecs++;
        if ({ready8, q8[2]} !== 5'b0010_0) begin errs++; $display("FAIL tog_start ready=%b q2=%b", ready8, q8[2]); end
        tick();
        set_req(1, 0, OP_HOLD, 3'd0, 3'd0);
        set_req(0, 1, OP_HOLD, 3'd0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            #1; vecs++;
            if ({busy8, ready8, q8[2]} !== {1'b1, 4'b0000, 1'(i % 2)}) begin
                errs++; $display("FAIL tog_burst i=%0d busy=%b ready=%b q2=%b", i, busy8, ready8, q8[2]);
            end
            tick();
        end
        #1; vecs++;
        if ({busy8, ready8, q8} !== {1'b0, 4'b0001, 8'hDF}) begin
            errs++; $display("FAIL tog_end busy=%b ready=%b q=%h exp 0/0001/df", busy8, ready8, q8);
        end
        tick();
        req_valid = '0; tick();
    endtask

    task automatic test_error();
        rst = 1'b1; req_valid = '0; tick(); rst = 1'b0;
        set_req(0, 1, OP_SET, 3'd1, 3'd0); tick();
        req_valid = '0; tick();
        set_req(2, 1, OP_SET, 3'd7, 3'd0); #1; vecs++;
        if ({err6, q6} !== 7'b0_000010) begin errs++; $display("FAIL err_pre err=%b q6=%h", err6, q6); end
        tick();
        req_valid = '0; #1; vecs++;
        if ({err6, busy6, err8} !== 3'b110) begin
            errs++; $display("FAIL err_pulse err6=%b busy6=%b err8=%b exp 1/1/0", err6, busy6, err8);
        end
        tick();
        #1; vecs++;
        if ({err6, busy6, q6, q8} !== {2'b00, 6'h02, 8'h82}) begin
            errs++; $display("FAIL err_after err6=%b busy6=%b q6=%h q8=%h", err6, busy6, q6, q8);
        end
        set_req(3, 1, OP_HOLD, 3'd0, 3'd0); tick();
        req_valid = '0; #1; vecs++;
        if ({busy8, err8, q8} !== {2'b10, 8'h82}) begin
            errs++; $display("FAIL hold_exec busy=%b err=%b q=%h", busy8, err8, q8);
        end
        tick();
        #1; vecs++;
        if ({busy8, q8} !== {1'b0, 8'h82}) begin errs++; $display("FAIL hold_done busy=%b q=%h", busy8, q8); end
    endtask

    task automatic test_midburst_reset();
        req_valid = '0;
        set_req(0, 1, OP_TOGGLE, 3'd0, 3'd7); tick();
        req_valid = '0; tick(); tick();
        rst = 1'b1; req_valid = 4'hF; #1; vecs++;
        if ({busy8, ready8} !== 5'b1_0000) begin errs++; $display("FAIL mid_rst busy=%b ready=%b", busy8, ready8); end
        tick();
        rst = 1'b0; #1; vecs++;
        if ({q8, busy8, ready8, gnt8} !== {8'h00, 1'b0, 4'b0001, 2'd0}) begin
            errs++; $display("FAIL mid_after q=%h busy=%b ready=%b gnt=%0d", q8, busy8, ready8, gnt8);
        end
        req_valid = '0; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = 4'($urandom);
            req_op    = 8'($urandom);
            req_addr  = 12'($urandom);
            req_len   = 12'($urandom);
            #1; vecs++;
            if ({ready8, busy8, q8, gnt8, err8} !== {exp_ready(), m_busy, m_q, 2'(m_gnt), 1'b0}) begin
                errs++;
                $display("FAIL rand c=%0d ready=%b/%b busy=%b/%b q=%h/%h gnt=%0d/%0d err=%b/0",
                         c, ready8, exp_ready(), busy8, m_busy, q8, m_q, gnt8, m_gnt, err8);
            end
            tick();
        end
        rst = 1'b0; req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_set();
        test_fairness();
        test_toggle();
        test_error();
        test_midburst_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
